// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO read-side stream consumer: FSM state
// encodings, output buffer depth, statistics counter widths and the
// credit check used to decide whether another pop fits in the buffer.
package fifo_reader_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int BUF_DEPTH = 2;

  localparam int STAT_WORDS_W  = 32;
  localparam int STAT_STARVE_W = 16;

  // A new pop is allowed when the words already buffered plus the one still
  // in flight, minus the one leaving this cycle, leave room for it.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       xfer);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    return pending < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream with burst framing. The reader drives it
// through the master modport, the downstream sink through the slave one.
interface fifo_stream_reader_if #(
  parameter int word_width = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [word_width-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_stream_reader_rd_skid_buffer.sv
// Two-entry output buffer for the FIFO stream reader. Words enter through a
// write port carrying {data,last}; the oldest word is always presented from
// the head register so the stream outputs stay stable while stalled.
module rd_skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter int word_width = 8
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [word_width-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [word_width-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            occ
);

  logic [word_width-1:0] head_data;
  logic                  head_last;
  logic [word_width-1:0] tail_data;
  logic                  tail_last;
  logic [1:0]            occ_q;
  logic                  xfer;

  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = head_data;
  assign rd_last  = head_last;
  assign occ      = occ_q;
  assign xfer     = rd_valid && rd_ready;

  // Move words head-ward on each transfer and place a newly captured word in
  // the first free slot; a simultaneous write and transfer keeps occupancy.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      case ({wr_en, xfer})
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_data <= wr_data;
            head_last <= wr_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= wr_data;
            tail_last <= wr_last;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_data <= tail_data;
            head_last <= tail_last;
          end
          occ_q <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_data <= wr_data;
            head_last <= wr_last;
            occ_q     <= 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_data <= wr_data;
            tail_last <= wr_last;
            occ_q     <= 2'd2;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the asynchronous FIFO, entirely in the r_clk domain.
// Pops words while enabled and there is buffer credit, captures them after
// rd_lat cycles and re-presents them on a valid/ready stream with m_last
// marking every burst_len-th word.
// Optional statistics outputs (stat_words, stat_starve) are built only when
// the macro FIFO_READER_STATS_EN is defined.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int word_width = 8,
  parameter int burst_len  = 4,
  parameter int rd_lat     = 1
) (
  input  logic                     r_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [word_width-1:0]    fifo_data,
  output logic                     fifo_rd,
  fifo_stream_reader_if.master     strm,
  output logic                     busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0]  stat_words,
  output logic [STAT_STARVE_W-1:0] stat_starve
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(burst_len - 1);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  xfer;
  logic                  cap_en;
  logic [word_width-1:0] cap_data;
  logic                  cap_last;
  logic [7:0]            burst_cnt;
  logic                  buf_valid;
  logic [word_width-1:0] buf_data;
  logic                  buf_last;

  assign strm.m_valid = buf_valid;
  assign strm.m_data  = buf_data;
  assign strm.m_last  = buf_last;
  assign xfer         = buf_valid && strm.m_ready;

  assign fifo_rd = (state_q == RUN) && !fifo_empty && credit_ok(occ, inflight, xfer);
  assign busy    = (state_q != IDLE) || (occ != 2'd0) || inflight;

  generate
    if (rd_lat == 0) begin : g_lat0
      assign inflight = 1'b0;
      assign cap_en   = fifo_rd;
      assign cap_data = fifo_data;
    end else begin : g_lat1
      logic inflight_q;

      // Remember that a pop was issued; its data is valid on the next cycle.
      always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
          inflight_q <= 1'b0;
        end else begin
          inflight_q <= fifo_rd;
        end
      end

      assign inflight = inflight_q;
      assign cap_en   = inflight_q;
      assign cap_data = fifo_data;
    end
  endgenerate

  // Words are delivered in capture order and every captured word is
  // delivered, so numbering them at capture gives each its burst position.
  assign cap_last = (burst_cnt == LAST_IDX);

  // Advance the burst position per word, wrapping after the last of a burst.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 8'd0;
    end else if (cap_en) begin
      burst_cnt <= cap_last ? 8'd0 : burst_cnt + 8'd1;
    end
  end

  // Next-state selection: enable starts or resumes reading, dropping it
  // drains outstanding words before returning to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  rd_skid_buffer #(
    .word_width(word_width)
  ) u_skid (
    .r_clk   (r_clk),
    .reset   (reset),
    .wr_en   (cap_en),
    .wr_data (cap_data),
    .wr_last (cap_last),
    .rd_valid(buf_valid),
    .rd_ready(strm.m_ready),
    .rd_data (buf_data),
    .rd_last (buf_last),
    .occ     (occ)
  );

`ifdef FIFO_READER_STATS_EN
  // Saturating counts of delivered words and of RUN cycles with nothing to send.
  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      stat_words  <= '0;
      stat_starve <= '0;
    end else begin
      if (xfer && (stat_words != '1)) begin
        stat_words <= stat_words + 1'b1;
      end
      if ((state_q == RUN) && fifo_empty && (occ == 2'd0) && (stat_starve != '1)) begin
        stat_starve <= stat_starve + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader (rd_lat=1, burst_len=4)
// with a small behavioural FIFO whose read data appears one cycle after a pop.
module tb_fifo_stream_reader;

  localparam int WW = 8;

  logic          r_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [WW-1:0] fifo_data = '0;
  logic          fifo_rd;
  logic          busy;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]   stat_words;
  logic [15:0]   stat_starve;
`endif

  fifo_stream_reader_if #(.word_width(WW)) m_if ();

  fifo_stream_reader #(
    .word_width(WW),
    .burst_len (4),
    .rd_lat    (1)
  ) dut (
    .r_clk     (r_clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .strm      (m_if.master),
    .busy      (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_starve(stat_starve)
`endif
  );

  always #5 r_clk = ~r_clk;

  // Behavioural FIFO: pointers survive the reader's reset.
  logic [WW-1:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  int underflow_count = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (fifo_rd) begin
      if (wr_ptr == rd_ptr) begin
        underflow_count <= underflow_count + 1;
      end else begin
        fifo_data <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
        pop_count <= pop_count + 1;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [WW-1:0] got_data [0:15];
  logic          got_last [0:15];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable = en;
    m_if.m_ready = rdy;
  endtask

  task automatic nextCycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic pushWord(input logic [WW-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic pulseReset();
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic collect(input int n, input int budget, output int got);
    int cycles;
    got = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      if (m_if.m_valid && m_if.m_ready) begin
        got_data[got] = m_if.m_data;
        got_last[got] = m_if.m_last;
        got++;
      end
      nextCycle();
      cycles++;
    end
  endtask

  task automatic settleIdle(input string tag);
    applyStimulus(1'b0, 1'b1);
    repeat (4) nextCycle();
    checkOutput(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got;
    int rd_pulses;
    int pop_base;

    m_if.m_ready = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset fifo_rd", fifo_rd, 1'b0);
    checkOutput("reset m_valid", m_if.m_valid, 1'b0);
    checkOutput("reset m_data", m_if.m_data, 8'h00);
    checkOutput("reset m_last", m_if.m_last, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    reset = 1'b0;

    // Reset while the buffer is full.
    for (int i = 0; i < 4; i++) pushWord(8'(8'hA0 + i));
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    checkOutput("t1 first pop", fifo_rd, 1'b1);
    repeat (3) nextCycle();
    checkOutput("t1 full m_valid", m_if.m_valid, 1'b1);
    checkOutput("t1 full m_data", m_if.m_data, 8'hA0);
    checkOutput("t1 full no pop", fifo_rd, 1'b0);
    checkOutput("t1 full busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("t1 async m_valid", m_if.m_valid, 1'b0);
    checkOutput("t1 async fifo_rd", fifo_rd, 1'b0);
    checkOutput("t1 async busy", busy, 1'b0);
    nextCycle();
    checkOutput("t1 held m_valid", m_if.m_valid, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1);
    collect(2, 12, got);
    checkOutput("t1 count", got, 2);
    checkOutput("t1 word0 data", got_data[0], 8'hA2);
    checkOutput("t1 word0 last", got_last[0], 1'b0);
    checkOutput("t1 word1 data", got_data[1], 8'hA3);
    checkOutput("t1 word1 last", got_last[1], 1'b0);
    checkOutput("t1 pops", pop_count, 4);
    settleIdle("t1 idle busy");

    // Eight preloaded words, sink always ready.
    pulseReset();
    for (int i = 0; i < 8; i++) pushWord(8'(8'h10 + i));
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    for (int c = 0; c < 12; c++) begin
      checkOutput($sformatf("t2 fifo_rd c%0d", c), fifo_rd, (c < 8) ? 1'b1 : 1'b0);
      checkOutput($sformatf("t2 m_valid c%0d", c), m_if.m_valid, (c >= 2 && c < 10) ? 1'b1 : 1'b0);
      if (c >= 2 && c < 10) begin
        checkOutput($sformatf("t2 m_data c%0d", c), m_if.m_data, 8'(8'h10 + c - 2));
        checkOutput($sformatf("t2 m_last c%0d", c), m_if.m_last, ((c - 2) % 4 == 3) ? 1'b1 : 1'b0);
      end
      nextCycle();
    end
    settleIdle("t2 idle busy");

    // Stalled sink: only two pops, head word held.
    pulseReset();
    pop_base = pop_count;
    for (int i = 0; i < 8; i++) pushWord(8'(8'h30 + i));
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    rd_pulses = 0;
    for (int c = 0; c < 8; c++) begin
      rd_pulses += int'(fifo_rd);
      if (c >= 2) checkOutput($sformatf("t3 hold data c%0d", c), m_if.m_data, 8'h30);
      nextCycle();
    end
    checkOutput("t3 pop pulses", rd_pulses, 2);
    checkOutput("t3 stalled m_valid", m_if.m_valid, 1'b1);
    checkOutput("t3 stalled m_last", m_if.m_last, 1'b0);
    applyStimulus(1'b1, 1'b1);
    collect(8, 30, got);
    checkOutput("t3 count", got, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3 data %0d", i), got_data[i], 8'(8'h30 + i));
      checkOutput($sformatf("t3 last %0d", i), got_last[i], (i % 4 == 3) ? 1'b1 : 1'b0);
    end
    checkOutput("t3 pops", pop_count - pop_base, 8);
    settleIdle("t3 idle busy");

    // FIFO runs dry after three words; a late fourth closes the burst.
    pulseReset();
    pop_base = pop_count;
    for (int i = 0; i < 3; i++) pushWord(8'(8'h50 + i));
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    collect(3, 12, got);
    checkOutput("t4 count", got, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4 data %0d", i), got_data[i], 8'(8'h50 + i));
      checkOutput($sformatf("t4 last %0d", i), got_last[i], 1'b0);
    end
    rd_pulses = 0;
    for (int c = 0; c < 5; c++) begin
      rd_pulses += int'(fifo_rd);
      nextCycle();
    end
    checkOutput("t4 empty pulses", rd_pulses, 0);
    checkOutput("t4 pops", pop_count - pop_base, 3);
    checkOutput("t4 underflow", underflow_count, 0);
    pushWord(8'h53);
    collect(1, 10, got);
    checkOutput("t4 late count", got, 1);
    checkOutput("t4 late data", got_data[0], 8'h53);
    checkOutput("t4 late last", got_last[0], 1'b1);
    settleIdle("t4 idle busy");

`ifdef FIFO_READER_STATS_EN
    // Five starved RUN cycles, then ten words delivered.
    pulseReset();
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    repeat (5) nextCycle();
    for (int i = 0; i < 10; i++) pushWord(8'(8'h70 + i));
    repeat (10) nextCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (6) nextCycle();
    checkOutput("stats words", stat_words, 32'd10);
    checkOutput("stats starve", stat_starve, 32'd5);
    checkOutput("stats busy", busy, 1'b0);
`endif

    // Drop enable with one word buffered and one in flight.
    pulseReset();
    pop_base = pop_count;
    for (int i = 0; i < 4; i++) pushWord(8'(8'h60 + i));
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    checkOutput("t5 pop c0", fifo_rd, 1'b1);
    nextCycle();
    checkOutput("t5 pop c1", fifo_rd, 1'b1);
    applyStimulus(1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 drain no pop", fifo_rd, 1'b0);
    checkOutput("t5 drain m_valid", m_if.m_valid, 1'b1);
    checkOutput("t5 drain busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b1);
    rd_pulses = 0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      rd_pulses += int'(fifo_rd);
      if (m_if.m_valid && m_if.m_ready && got < 16) begin
        got_data[got] = m_if.m_data;
        got_last[got] = m_if.m_last;
        got++;
      end
      nextCycle();
    end
    checkOutput("t5 count", got, 2);
    checkOutput("t5 data 0", got_data[0], 8'h60);
    checkOutput("t5 last 0", got_last[0], 1'b0);
    checkOutput("t5 data 1", got_data[1], 8'h61);
    checkOutput("t5 last 1", got_last[1], 1'b0);
    checkOutput("t5 pulses after drop", rd_pulses, 0);
    checkOutput("t5 idle busy", busy, 1'b0);
    checkOutput("t5 pops", pop_count - pop_base, 2);
    checkOutput("final underflow", underflow_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
